// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Optional leading-zero blank mask is built only when BIN_TO_BCD_BLANK_EN is defined.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     digit_blank
);

  localparam int CW = $clog2(WIDTH + 1);

  function automatic bit digits_fit();
    longint unsigned pow10 = 64'd1;
    for (int i = 0; i < DIGITS; i++) pow10 = pow10 * 64'd10;
    return pow10 > ((64'd1 << WIDTH) - 64'd1);
  endfunction

  localparam bit DIGITS_FIT = digits_fit();

  generate
    if (!DIGITS_FIT) begin : g_bad_digits
      $error("bin_to_bcd_seq: DIGITS too small to hold 2**WIDTH-1");
    end
  endgenerate

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      shreg_q, shreg_d;
  logic [4*DIGITS-1:0]   scratch_q, scratch_d;
  logic [4*DIGITS-1:0]   adj;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  done_q, done_d;

  // Add-3 correction before each shift keeps every digit at or below 9 afterwards.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d   = bin;
          scratch_d = '0;
          cnt_d     = CW'(WIDTH);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_d, shreg_d} = {adj, shreg_q} << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = scratch_d;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign bcd  = bcd_q;

`ifdef BIN_TO_BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic              zero_above;

  // Mask is derived from the result being written, so it moves on the same edge as bcd.
  always_comb begin
    blank_d    = blank_q;
    zero_above = 1'b1;
    if (done_d) begin
      blank_d[0] = 1'b0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
        zero_above = zero_above & (bcd_d[4*i +: 4] == 4'd0);
        blank_d[i] = zero_above;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) blank_q <= ~DIGITS'(1);
    else       blank_q <= blank_d;
  end

  assign digit_blank = blank_q;
`else
  assign digit_blank = '0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (WIDTH=16, DIGITS=5).
// Blank-mask expectations follow BIN_TO_BCD_BLANK_EN when the bench is built with it.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic [19:0] bcd;
  logic [4:0]  digit_blank;

  int checks   = 0;
  int failures = 0;

`ifdef BIN_TO_BCD_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .bin         (bin),
    .busy        (busy),
    .done        (done),
    .bcd         (bcd),
    .digit_blank (digit_blank)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] bl(input logic [4:0] mask);
    return BLANK_EN ? mask : 5'b00000;
  endfunction

  // Runs from just after the accepting edge until done is seen (bounded at 40 cycles).
  task automatic run_until_done(input logic [19:0] hold_exp, input int poke_at,
                                output int n, output int busy_cnt, output bit hold_ok);
    n = 0;
    busy_cnt = 0;
    hold_ok = 1'b1;
    while (!done && n < 40) begin
      if (busy) busy_cnt++;
      if (bcd !== hold_exp) hold_ok = 1'b0;
      start = (n == poke_at);
      bin   = (n == poke_at) ? 16'd9999 : 16'($urandom);
      tick();
      n++;
    end
    start = 1'b0;
  endtask

  task automatic convert(input string tag, input logic [15:0] v, input logic [19:0] prev,
                         input logic [19:0] exp, input logic [4:0] exp_bl, input int poke_at);
    int n, bc;
    bit hold;
    start = 1'b1;
    bin   = v;
    tick();
    start = 1'b0;
    run_until_done(prev, poke_at, n, bc, hold);
    check({tag, "_latency"}, n, 16);
    check({tag, "_busy_cycles"}, bc, 16);
    check({tag, "_bcd_hold"}, hold, 1);
    check({tag, "_done"}, done, 1);
    check({tag, "_bcd"}, bcd, exp);
    check({tag, "_blank"}, digit_blank, bl(exp_bl));
    tick();
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_bcd_stable"}, bcd, exp);
  endtask

  initial begin
    int n, bc;
    bit hold, quiet;

    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    tick();
    tick();
    reset = 1'b0;
    repeat (5) tick();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_bcd", bcd, 20'h00000);
    check("reset_blank", digit_blank, bl(5'b11110));

    convert("zero", 16'd0, 20'h00000, 20'h00000, 5'b11110, -1);
    convert("nine", 16'd9, 20'h00000, 20'h00009, 5'b11110, -1);
    convert("max", 16'd65535, 20'h00009, 20'h65535, 5'b00000, -1);

    // Second start 5 cycles in must be ignored and not queued.
    convert("ignore", 16'd1234, 20'h65535, 20'h01234, 5'b10000, 4);
    quiet = 1'b1;
    repeat (20) begin
      if (busy || done) quiet = 1'b0;
      tick();
    end
    check("ignore_no_second_conv", quiet, 1);

    // Back-to-back: start for 42 in the done cycle of 100.
    start = 1'b1;
    bin   = 16'd100;
    tick();
    start = 1'b0;
    run_until_done(20'h01234, -1, n, bc, hold);
    check("b2b_first_latency", n, 16);
    check("b2b_first_bcd", bcd, 20'h00100);
    check("b2b_first_blank", digit_blank, bl(5'b11100));
    start = 1'b1;
    bin   = 16'd42;
    tick();
    start = 1'b0;
    check("b2b_accept_busy", busy, 1);
    check("b2b_accept_done", done, 0);
    run_until_done(20'h00100, -1, n, bc, hold);
    check("b2b_second_latency", n, 16);
    check("b2b_second_hold", hold, 1);
    check("b2b_second_bcd", bcd, 20'h00042);
    check("b2b_second_blank", digit_blank, bl(5'b11100));
    tick();
    check("b2b_done_one_cycle", done, 0);

    convert("v305", 16'd305, 20'h00042, 20'h00305, 5'b11000, -1);

    // Reset 8 cycles into a conversion aborts it.
    start = 1'b1;
    bin   = 16'd500;
    tick();
    start = 1'b0;
    repeat (7) tick();
    check("abort_busy_before", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_bcd", bcd, 20'h00000);
    check("abort_blank", digit_blank, bl(5'b11110));
    quiet = 1'b1;
    repeat (20) begin
      if (busy || done) quiet = 1'b0;
      tick();
    end
    check("abort_no_done", quiet, 1);

    convert("seven", 16'd7, 20'h00000, 20'h00007, 5'b11110, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
